// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
   localparam int PC_W        = 64;
   localparam int INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HOLD  = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/fetch_pc_reg.sv
// Program-counter register with its next-PC mux: reset, redirect load, +4 advance, or hold.
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [PC_W-1:0] target,
   input  logic            advance,
   output logic [PC_W-1:0] pc
);

   // Load and advance are never both asserted by the parent; load still wins.
   always_ff @(posedge clk) begin
      if (reset)
         pc <= RESET_PC;
      else if (load)
         pc <= target;
      else if (advance)
         pc <= pc + PC_W'(INSTR_BYTES);
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IF/ID register with valid/ready output, redirect and fetch counter.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          COUNT_W  = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fetch_en,
   input  logic               redirect,
   input  logic [63:0]        redirect_target,
   output logic [63:0]        Inst_Address,
   input  logic [31:0]        instruction,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [31:0]        id_instr,
   output logic [63:0]        id_pc,
   output logic [COUNT_W-1:0] fetch_count,
   output logic               fetch_fault,
   output logic [1:0]         state
);

   localparam logic [1:0] S_RUN   = 2'(RUN);
   localparam logic [1:0] S_HOLD  = 2'(HOLD);
   localparam logic [1:0] S_FAULT = 2'(FAULT);

   logic            cap;
   logic            misalign;
   logic            pc_load;
   logic [PC_W-1:0] load_target;

   // Handshake: the IF/ID word transfers on a cycle where id_valid && id_ready;
   // id_valid, once high, stays high with stable contents until that transfer,
   // a redirect flush, or reset.
   assign cap = (state == S_RUN) && fetch_en && !redirect && (!id_valid || id_ready);

`ifdef FETCH_MISALIGN_TRAP_EN
   assign misalign    = redirect && (redirect_target[1:0] != 2'b00) && (state != S_FAULT);
   assign pc_load     = redirect && !misalign && (state != S_FAULT);
   assign load_target = redirect_target;
   assign fetch_fault = (state == S_FAULT);
`else
   assign misalign    = 1'b0;
   assign pc_load     = redirect;
   assign load_target = redirect_target & ~64'h3;
   assign fetch_fault = 1'b0;
`endif

   fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
      .clk     (clk),
      .reset   (reset),
      .load    (pc_load),
      .target  (load_target),
      .advance (cap),
      .pc      (Inst_Address)
   );

   // FAULT is sticky; otherwise the state simply tracks fetch_en from the previous cycle.
   always_ff @(posedge clk) begin
      if (reset)
         state <= S_RUN;
      else if (state == S_FAULT || misalign)
         state <= S_FAULT;
      else
         state <= fetch_en ? S_RUN : S_HOLD;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         id_valid <= 1'b0;
         id_instr <= NOP_INSTR;
         id_pc    <= '0;
      end else if (redirect) begin
         id_valid <= 1'b0;
      end else if (cap) begin
         id_valid <= 1'b1;
         id_instr <= instruction;
         id_pc    <= Inst_Address;
      end else if (id_valid && id_ready) begin
         id_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         fetch_count <= '0;
      else if (cap)
         fetch_count <= fetch_count + 1'b1;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then randomized traffic vs. a reference model.
module tb_fetch_unit;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_en;
   logic        redirect;
   logic [63:0] redirect_target;
   logic [63:0] Inst_Address;
   logic [31:0] instruction;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [63:0] id_pc;
   logic [31:0] fetch_count;
   logic        fetch_fault;
   logic [1:0]  state;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(64'h0), .COUNT_W(32)) dut (
      .clk             (clk),
      .reset           (reset),
      .fetch_en        (fetch_en),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .Inst_Address    (Inst_Address),
      .instruction     (instruction),
      .id_valid        (id_valid),
      .id_ready        (id_ready),
      .id_instr        (id_instr),
      .id_pc           (id_pc),
      .fetch_count     (fetch_count),
      .fetch_fault     (fetch_fault),
      .state           (state)
   );

   // Combinational instruction memory, 64 words, aliased by address bits [7:2].
   logic [31:0] mem [0:63];
   assign instruction = mem[Inst_Address[7:2]];

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model of the architectural state.
   logic [63:0]  m_pc;
   logic         m_valid;
   logic [31:0]  m_instr;
   logic [63:0]  m_idpc;
   logic [31:0]  m_count;
   logic         m_fault;
   fetch_state_t m_state;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_step();
      logic [31:0] word;
      bit          take;
      word = mem[m_pc[7:2]];
      if (reset) begin
         m_pc    = 64'h0;
         m_valid = 1'b0;
         m_instr = NOP_INSTR;
         m_idpc  = 64'h0;
         m_count = 32'h0;
         m_fault = 1'b0;
         m_state = RUN;
      end else begin
         take = (m_state == RUN) && fetch_en && !redirect && (!m_valid || id_ready);
         if (redirect && m_state != FAULT) begin
            m_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_target[1:0] != 2'b00) begin
               m_fault = 1'b1;
               m_state = FAULT;
            end else begin
               m_pc = redirect_target;
            end
`else
            m_pc = {redirect_target[63:2], 2'b00};
`endif
         end else if (take) begin
            m_instr = word;
            m_idpc  = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 64'd4;
            m_count = m_count + 32'd1;
         end else if (m_valid && id_ready) begin
            m_valid = 1'b0;
         end
         if (m_state != FAULT)
            m_state = fetch_en ? RUN : HOLD;
      end
   endtask

   task automatic check_all();
      chk("inst_address", Inst_Address, m_pc);
      chk("id_valid", 64'(id_valid), 64'(m_valid));
      if (m_valid) begin
         chk("id_instr", 64'(id_instr), 64'(m_instr));
         chk("id_pc", id_pc, m_idpc);
      end
      chk("fetch_count", 64'(fetch_count), 64'(m_count));
      chk("fetch_fault", 64'(fetch_fault), 64'(m_fault));
      chk("state", 64'(state), 64'(m_state));
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[0] = 32'h00B5_04B3;
      mem[1] = 32'h40D4_8633;
      mem[2] = 32'h0096_66B3;

      reset = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_target = 64'h0; id_ready = 1'b0;
      m_pc = 64'h0; m_valid = 1'b0; m_instr = NOP_INSTR; m_idpc = 64'h0;
      m_count = 32'h0; m_fault = 1'b0; m_state = RUN;
      cyc();
      cyc();
      chk("rst_addr", Inst_Address, 64'h0);
      chk("rst_valid", 64'(id_valid), 64'h0);
      chk("rst_instr", 64'(id_instr), 64'h13);
      chk("rst_count", 64'(fetch_count), 64'h0);

      // Sequential fetch
      reset = 1'b0; fetch_en = 1'b1; id_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("seq_pc", id_pc, 64'(i * 4));
         if (i == 0) chk("seq_instr0", 64'(id_instr), 64'h00B5_04B3);
         if (i == 1) chk("seq_instr1", 64'(id_instr), 64'h40D4_8633);
      end
      chk("seq_count", 64'(fetch_count), 64'd4);

      // Backpressure
      id_ready = 1'b0;
      repeat (3) cyc();
      chk("bp_pc", id_pc, 64'd12);
      chk("bp_addr", Inst_Address, 64'd16);
      chk("bp_count", 64'(fetch_count), 64'd4);
      chk("bp_valid", 64'(id_valid), 64'd1);
      id_ready = 1'b1;
      cyc();
      chk("bp_release_pc", id_pc, 64'd16);
      chk("bp_release_count", 64'(fetch_count), 64'd5);

      // Redirect with a live IF/ID entry
      redirect = 1'b1; redirect_target = 64'h4;
      cyc();
      redirect = 1'b0;
      cyc();
      chk("rd_pre_pc", id_pc, 64'h4);
      redirect = 1'b1; redirect_target = 64'h8;
      cyc();
      redirect = 1'b0;
      chk("rd_flush", 64'(id_valid), 64'h0);
      chk("rd_addr", Inst_Address, 64'h8);
      cyc();
      chk("rd_tgt_pc", id_pc, 64'h8);
      chk("rd_tgt_instr", 64'(id_instr), 64'h0096_66B3);

      // fetch_en low with a redirect inside the window
      fetch_en = 1'b0;
      cyc();
      chk("hold_state", 64'(state), 64'(HOLD));
      redirect = 1'b1; redirect_target = 64'hC;
      cyc();
      redirect = 1'b0;
      chk("hold_addr", Inst_Address, 64'hC);
      chk("hold_count", 64'(fetch_count), 64'd7);
      fetch_en = 1'b1;
      cyc();
      cyc();
      chk("resume_pc", id_pc, 64'hC);
      chk("resume_valid", 64'(id_valid), 64'h1);

      // Reset during a stall
      id_ready = 1'b0;
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("mid_rst_valid", 64'(id_valid), 64'h0);
      chk("mid_rst_addr", Inst_Address, 64'h0);
      chk("mid_rst_instr", 64'(id_instr), 64'h13);
      chk("mid_rst_count", 64'(fetch_count), 64'h0);

      // PC wrap
      id_ready = 1'b1;
      redirect = 1'b1; redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
      cyc();
      redirect = 1'b0;
      cyc();
      chk("wrap_addr", Inst_Address, 64'h0);
      chk("wrap_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);

      // Misaligned redirect
      redirect = 1'b1; redirect_target = 64'h10;
      cyc();
      redirect = 1'b0;
      cyc();
      redirect = 1'b1; redirect_target = 64'h6;
      cyc();
      redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("mis_fault", 64'(fetch_fault), 64'h1);
      chk("mis_valid", 64'(id_valid), 64'h0);
      chk("mis_addr", Inst_Address, 64'h14);
      repeat (3) cyc();
      chk("mis_sticky", 64'(state), 64'(FAULT));
      chk("mis_hold_addr", Inst_Address, 64'h14);
`else
      chk("mis_addr", Inst_Address, 64'h4);
      chk("mis_fault", 64'(fetch_fault), 64'h0);
`endif
      reset = 1'b1;
      cyc();
      reset = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         reset    = ($urandom_range(0, 99) == 0);
         fetch_en = ($urandom_range(0, 9) != 0);
         id_ready = ($urandom_range(0, 3) != 0);
         redirect = ($urandom_range(0, 9) == 0);
         redirect_target = 64'($urandom_range(0, 63) * 4);
         if ($urandom_range(0, 7) == 0)
            redirect_target = redirect_target + 64'($urandom_range(1, 3));
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that owns the program counter. It drives the byte address into the combinational `Instruction_Memory` and captures the returned 32-bit word, together with its PC, into an IF/ID pipeline register. That register feeds the decoder through a valid/ready handshake. The stage also handles taken-branch/jump redirects, decoder backpressure, a fetch enable, and a fetched-instruction counter.

## Interface
- `RESET_PC`, default 64'h0: PC value loaded on reset.
- `COUNT_W`, default 32: width of the fetched-instruction counter.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `fetch_en`  in  1: when low, no new fetch is issued; PC holds.
- `redirect`  in  1: taken branch/jump from execute; PC must be reloaded.
- `redirect_target`  in  64: new PC, byte address.
- `Inst_Address`  out  64: PC register, driven straight to instruction memory.
- `instruction`  in  32: memory read data, valid in the same cycle as `Inst_Address`.
- `id_valid`  out  1: IF/ID register holds a live instruction.
- `id_ready`  in  1: decoder accepts the IF/ID contents this cycle.
- `id_instr`  out  32: captured instruction word.
- `id_pc`  out  64: PC of `id_instr`.
- `fetch_count`  out  COUNT_W: instructions captured since reset; wraps.
- `fetch_fault`  out  1: misaligned redirect detected. Present only with the macro enabled; otherwise tied 0.

## Operation
- States:
  - RUN: normal fetching.
  - HOLD: `fetch_en` low.
  - FAULT: macro build only; terminal until reset.
- Capture condition: `cap = state==RUN && fetch_en && !redirect && (!id_valid || id_ready)`.
- On `cap`:
  - `id_instr <= instruction`, `id_pc <= PC`, `id_valid <= 1`.
  - `PC <= PC + 4`, modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
  - `fetch_count` increments, wrapping at 2^COUNT_W.
- Handshake:
  - If `id_valid && id_ready && !cap`, then `id_valid <= 0`.
  - If `id_valid && !id_ready`, all IF/ID fields and PC hold.
  - No skid buffer; throughput is one instruction per cycle while `id_ready` is high.
- Redirect has highest priority, except for reset:
  - `PC <= redirect_target` and `id_valid <= 0` (flush), regardless of `id_ready` or `fetch_en`.
  - No capture happens in that cycle.
  - The first instruction at the target is captured on the next cycle.
- `fetch_en` low:
  - Move to HOLD; PC and counter hold.
  - A pending `id_valid` may still drain via `id_ready`.
  - Redirect is still honoured in HOLD.
  - Return to RUN when `fetch_en` is high.
- Reset (wins over everything, including mid-handshake or mid-redirect):
  - `PC = RESET_PC`, `id_valid = 0`, `id_instr = 32'h0000_0013` (NOP), `id_pc = 0`, `fetch_count = 0`, `fetch_fault = 0`.
  - State = RUN.

## Timing
- `Inst_Address` is a register output; no combinational path from any input to it.
- `instruction` is sampled in the same cycle `Inst_Address` is presented. There is zero memory latency; memory is combinational.
- Fetch-to-decode latency is 1 cycle: an address presented in cycle N appears on `id_instr`/`id_pc` with `id_valid` in cycle N+1.
- Redirect penalty is 1 bubble: redirect in cycle N, target on `Inst_Address` in N+1, target instruction valid at ID in N+2.
- `id_valid` never drops while `id_ready` is low, except on redirect or reset.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_target[1:0] != 0` loads nothing.
  - It sets `fetch_fault` and flushes `id_valid`.
  - It enters FAULT, where no captures occur and PC holds; only reset exits.
- `FETCH_MISALIGN_TRAP_EN` undefined:
  - `redirect_target[1:0]` is forced to 0 when loaded into PC.
  - No FAULT state exists; `fetch_fault` is constant 0.

## Structure
- Package `fetch_pkg` holds:
  - the state enum `fetch_state_t` {RUN, HOLD, FAULT};
  - `INSTR_BYTES = 4`;
  - `NOP_INSTR = 32'h0000_0013`;
  - `PC_W = 64`.
- One sub-module, `fetch_pc_reg`, holds the PC register and next-PC mux (reset / redirect / +4 / hold).
- The IF/ID register, handshake, counter and FSM stay in `fetch_unit`.

## Test plan
- Sequential fetch: reset, then `fetch_en=1`, `id_ready=1` with the real instruction memory, `RESET_PC=0` → `id_pc` reads 0, 4, 8, 12 on consecutive cycles; `id_instr` reads 0x00B504B3, then 0x40D48633; `fetch_count=4` after 4 captures.
- Backpressure: `id_ready=0` for 3 cycles while `id_valid=1` → `id_pc`, `id_instr`, `Inst_Address` and `fetch_count` stable. On release, the next capture occurs the same cycle.
- Redirect: redirect to 0x8 while `id_valid=1` with `id_pc=0x4` → next cycle `id_valid=0` and `Inst_Address=0x8`. The cycle after that, `id_pc=0x8` and `id_instr=0x009666B3`.
- `fetch_en` low 2 cycles, plus a redirect to 0xC during that window → no captures, `Inst_Address=0xC`, state HOLD. Fetch resumes at 0xC when `fetch_en` goes high.
- Reset mid-stall with `id_valid=1`, `id_ready=0` → next cycle all outputs at their reset values and `Inst_Address=RESET_PC`. PC wrap: force PC to 64'hFFFF_FFFF_FFFF_FFFC → the next `Inst_Address` is 0.
- Misaligned redirect to 0x6:
  - With `FETCH_MISALIGN_TRAP_EN`: `fetch_fault=1`, `id_valid=0`, PC holds, and the block stays faulted until reset.
  - Without the macro: `Inst_Address=0x4`.
